// File: rtl/alu_operand_collector.sv
// alu_operand_collector
//   Staging block in front of the ALU core. Collects opa/opb that may arrive
//   together or in separate cycles, holds the command context while one
//   operand is outstanding, and issues a single registered operation. If the
//   missing operand does not show up within TIMEOUT enabled cycles, the
//   partial operation is dropped and timeout_err pulses for one cycle.
//
//   Optional build macro: ALU_COLLECT_STATS_EN adds saturating 16-bit
//   counters iss_cnt (issued ops) and tmo_cnt (timeouts).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   ce                clock enable, 0 freezes everything
//   mode, cin, cmd    command context (1 = arithmetic, 0 = logical)
//   inp_valid[1:0]    bit0 = opa valid, bit1 = opb valid
//   opa, opb          operands
//   iss_valid         one-cycle issue pulse
//   iss_mode/cin/cmd  issued context, held until the next issue
//   iss_opa/opb       issued operands, held until the next issue
//   timeout_err       one-cycle pulse when a waiting op is abandoned
//   busy              high while waiting for a second operand
//
// state  | meaning
// IDLE   | no partial op held, ready for a new op
// WAIT_A | opb and context held, waiting for opa
// WAIT_B | opa and context held, waiting for opb

module alu_operand_collector #(
   parameter int WIDTH     = 8,
   parameter int CMD_WIDTH = 4,
   parameter int TIMEOUT   = 16,
   parameter logic [2**CMD_WIDTH-1:0] TWO_OP_ARITH = 16'h0F07,
   parameter logic [2**CMD_WIDTH-1:0] TWO_OP_LOGIC = 16'h003F
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic                 mode,
   input  logic                 cin,
   input  logic [CMD_WIDTH-1:0] cmd,
   input  logic [1:0]           inp_valid,
   input  logic [WIDTH-1:0]     opa,
   input  logic [WIDTH-1:0]     opb,
   output logic                 iss_valid,
   output logic                 iss_mode,
   output logic                 iss_cin,
   output logic [CMD_WIDTH-1:0] iss_cmd,
   output logic [WIDTH-1:0]     iss_opa,
   output logic [WIDTH-1:0]     iss_opb,
`ifdef ALU_COLLECT_STATS_EN
   output logic [15:0]          iss_cnt,
   output logic [15:0]          tmo_cnt,
`endif
   output logic                 timeout_err,
   output logic                 busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // A wait cycle that starts with the counter here is the last one allowed.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_A = 2'd1,
      WAIT_B = 2'd2
   } state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic                 hold_mode, hold_mode_n;
   logic                 hold_cin, hold_cin_n;
   logic [CMD_WIDTH-1:0] hold_cmd, hold_cmd_n;
   logic [WIDTH-1:0]     hold_op, hold_op_n;

   logic                 issue, tmo;
   logic                 nx_mode, nx_cin;
   logic [CMD_WIDTH-1:0] nx_cmd;
   logic [WIDTH-1:0]     nx_opa, nx_opb;
   logic                 need2;

   assign need2 = mode ? TWO_OP_ARITH[cmd] : TWO_OP_LOGIC[cmd];
   assign busy  = (state != IDLE);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      hold_mode_n = hold_mode;
      hold_cin_n  = hold_cin;
      hold_cmd_n  = hold_cmd;
      hold_op_n   = hold_op;
      issue       = 1'b0;
      tmo         = 1'b0;
      nx_mode     = iss_mode;
      nx_cin      = iss_cin;
      nx_cmd      = iss_cmd;
      nx_opa      = iss_opa;
      nx_opb      = iss_opb;

      case (state)
         IDLE: begin
            if (inp_valid == 2'b11 || (inp_valid != 2'b00 && !need2)) begin
               issue   = 1'b1;
               nx_mode = mode;
               nx_cin  = cin;
               nx_cmd  = cmd;
               nx_opa  = inp_valid[0] ? opa : '0;
               nx_opb  = inp_valid[1] ? opb : '0;
            end else if (inp_valid != 2'b00) begin
               hold_mode_n = mode;
               hold_cin_n  = cin;
               hold_cmd_n  = cmd;
               hold_op_n   = inp_valid[0] ? opa : opb;
               cnt_n       = '0;
               state_n     = inp_valid[0] ? WAIT_B : WAIT_A;
            end
         end

         WAIT_A, WAIT_B: begin
            // Only the missing operand is taken; the held one is never replaced.
            if ((state == WAIT_A && inp_valid[0]) || (state == WAIT_B && inp_valid[1])) begin
               issue   = 1'b1;
               nx_mode = hold_mode;
               nx_cin  = hold_cin;
               nx_cmd  = hold_cmd;
               nx_opa  = (state == WAIT_A) ? opa : hold_op;
               nx_opb  = (state == WAIT_A) ? hold_op : opb;
               cnt_n   = '0;
               state_n = IDLE;
            end else if (cnt == CNT_LAST) begin
               tmo     = 1'b1;
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end

         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         hold_mode   <= 1'b0;
         hold_cin    <= 1'b0;
         hold_cmd    <= '0;
         hold_op     <= '0;
         iss_valid   <= 1'b0;
         timeout_err <= 1'b0;
         iss_mode    <= 1'b0;
         iss_cin     <= 1'b0;
         iss_cmd     <= '0;
         iss_opa     <= '0;
         iss_opb     <= '0;
      end else if (ce) begin
         state       <= state_n;
         cnt         <= cnt_n;
         hold_mode   <= hold_mode_n;
         hold_cin    <= hold_cin_n;
         hold_cmd    <= hold_cmd_n;
         hold_op     <= hold_op_n;
         iss_valid   <= issue;
         timeout_err <= tmo;
         iss_mode    <= nx_mode;
         iss_cin     <= nx_cin;
         iss_cmd     <= nx_cmd;
         iss_opa     <= nx_opa;
         iss_opb     <= nx_opb;
      end else begin
         // Pulses must not stretch across a frozen cycle.
         iss_valid   <= 1'b0;
         timeout_err <= 1'b0;
      end
   end

`ifdef ALU_COLLECT_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_cnt <= '0;
         tmo_cnt <= '0;
      end else if (ce) begin
         if (issue && iss_cnt != 16'hFFFF) iss_cnt <= iss_cnt + 16'd1;
         if (tmo && tmo_cnt != 16'hFFFF)   tmo_cnt <= tmo_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_operand_collector.sv
module tb_alu_operand_collector;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ce = 1'b1;
   logic       mode = 1'b0;
   logic       cin = 1'b0;
   logic [3:0] cmd = '0;
   logic [1:0] inp_valid = '0;
   logic [7:0] opa = '0;
   logic [7:0] opb = '0;
   logic       iss_valid, iss_mode, iss_cin, timeout_err, busy;
   logic [3:0] iss_cmd;
   logic [7:0] iss_opa, iss_opb;
`ifdef ALU_COLLECT_STATS_EN
   logic [15:0] iss_cnt, tmo_cnt;
`endif

   always #5 clk = ~clk;

   alu_operand_collector dut (
      .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cin(cin), .cmd(cmd),
      .inp_valid(inp_valid), .opa(opa), .opb(opb),
      .iss_valid(iss_valid), .iss_mode(iss_mode), .iss_cin(iss_cin),
      .iss_cmd(iss_cmd), .iss_opa(iss_opa), .iss_opb(iss_opb),
`ifdef ALU_COLLECT_STATS_EN
      .iss_cnt(iss_cnt), .tmo_cnt(tmo_cnt),
`endif
      .timeout_err(timeout_err), .busy(busy)
   );

   int checks = 0;
   int failures = 0;
   int exp_iss = 0;
   int exp_tmo = 0;

   // Packed event: {iss_valid, timeout_err, mode, cin, cmd[3:0], opa[7:0], opb[7:0]}
   logic [23:0] exp_q[$];
   logic [21:0] last_ctx = '0;

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_issue(input logic m, input logic c, input logic [3:0] k,
                             input logic [7:0] a, input logic [7:0] b);
      last_ctx = {m, c, k, a, b};
      exp_q.push_back({2'b10, m, c, k, a, b});
      exp_iss++;
   endtask

   task automatic push_tmo();
      exp_q.push_back({2'b01, last_ctx});
      exp_tmo++;
   endtask

   // Apply inputs, let one rising edge sample them, return 1 ns after it.
   task automatic cyc(input logic [1:0] iv, input logic m, input logic c,
                      input logic [3:0] k, input logic [7:0] a, input logic [7:0] b);
      inp_valid = iv; mode = m; cin = c; cmd = k; opa = a; opb = b;
      @(posedge clk); #1;
   endtask

   task automatic idle_cyc();
      cyc(2'b00, 1'b0, 1'b1, 4'h8, 8'hEE, 8'hDD);
   endtask

   always @(negedge clk) begin
      if (!rst && (iss_valid || timeout_err)) begin
         if (exp_q.size() == 0)
            chk("unexpected_event", {iss_valid, timeout_err, iss_mode, iss_cin, iss_cmd, iss_opa, iss_opb}, 24'h0);
         else
            chk("scoreboard", {iss_valid, timeout_err, iss_mode, iss_cin, iss_cmd, iss_opa, iss_opb},
                exp_q.pop_front());
      end
   end

   initial begin
      #12;
      chk("reset_outputs", {iss_valid, timeout_err, busy, iss_mode, iss_cin, iss_cmd, iss_opa}, 24'h0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Same-cycle operands
      push_issue(1'b1, 1'b0, 4'h0, 8'h12, 8'h34);
      cyc(2'b11, 1'b1, 1'b0, 4'h0, 8'h12, 8'h34);
      chk("same_cycle_busy", {23'd0, busy}, 24'd0);
      chk("same_cycle_valid", {23'd0, iss_valid}, 24'd1);
      idle_cyc();

      // Split arrival; context inputs during the wait are junk and must be ignored
      push_issue(1'b1, 1'b0, 4'h0, 8'h05, 8'h07);
      cyc(2'b01, 1'b1, 1'b0, 4'h0, 8'h05, 8'h99);
      chk("split_busy0", {23'd0, busy}, 24'd1);
      for (int i = 1; i <= 3; i++) begin
         idle_cyc();
         chk("split_busy", {23'd0, busy}, 24'd1);
      end
      cyc(2'b10, 1'b0, 1'b1, 4'h8, 8'hFF, 8'h07);
      chk("split_done", {22'd0, busy, iss_valid}, 24'd1);
      idle_cyc();

      // Timeout after 16 wait cycles
      push_tmo();
      cyc(2'b10, 1'b1, 1'b0, 4'h0, 8'h00, 8'hAA);
      for (int i = 1; i <= 15; i++) idle_cyc();
      chk("tmo_before", {22'd0, busy, timeout_err}, 24'd2);
      idle_cyc();
      chk("tmo_pulse", {21'd0, busy, timeout_err, iss_valid}, 24'd2);
      idle_cyc();
      chk("tmo_one_shot", {23'd0, timeout_err}, 24'd0);

      // Boundary: operand on the 16th wait cycle wins
      push_issue(1'b1, 1'b1, 4'h0, 8'h01, 8'hAA);
      cyc(2'b10, 1'b1, 1'b1, 4'h0, 8'h00, 8'hAA);
      for (int i = 1; i <= 15; i++) idle_cyc();
      cyc(2'b01, 1'b0, 1'b0, 4'h5, 8'h01, 8'h00);
      chk("boundary", {21'd0, busy, timeout_err, iss_valid}, 24'd1);

      // Both bits valid while waiting: held opa must survive
      push_issue(1'b1, 1'b0, 4'h1, 8'h33, 8'h44);
      cyc(2'b01, 1'b1, 1'b0, 4'h1, 8'h33, 8'h00);
      cyc(2'b11, 1'b1, 1'b1, 4'h9, 8'h99, 8'h44);

      // Back-to-back issue, including single-operand commands
      push_issue(1'b0, 1'b0, 4'h8, 8'h00, 8'hF0);
      cyc(2'b10, 1'b0, 1'b0, 4'h8, 8'h77, 8'hF0);
      push_issue(1'b1, 1'b1, 4'h3, 8'h5A, 8'h00);
      cyc(2'b01, 1'b1, 1'b1, 4'h3, 8'h5A, 8'h66);
      chk("single_op_opb_zero", {16'd0, iss_opb}, 24'h0);
      push_issue(1'b0, 1'b1, 4'h2, 8'hC3, 8'h3C);
      cyc(2'b11, 1'b0, 1'b1, 4'h2, 8'hC3, 8'h3C);
      idle_cyc();

      // ce freeze in WAIT_B, then resume counting
      push_tmo();
      cyc(2'b01, 1'b1, 1'b0, 4'h0, 8'h21, 8'h00);
      ce = 1'b0;
      for (int i = 0; i < 30; i++) idle_cyc();
      chk("freeze_busy", {22'd0, busy, timeout_err}, 24'd2);
      ce = 1'b1;
      for (int i = 1; i <= 15; i++) idle_cyc();
      chk("resume_before", {22'd0, busy, timeout_err}, 24'd2);
      idle_cyc();
      chk("resume_tmo", {22'd0, busy, timeout_err}, 24'd1);
      idle_cyc();

`ifdef ALU_COLLECT_STATS_EN
      chk("iss_cnt", {8'd0, iss_cnt}, 24'(exp_iss));
      chk("tmo_cnt", {8'd0, tmo_cnt}, 24'(exp_tmo));
`endif
      chk("queue_drained", 24'(exp_q.size()), 24'd0);

      // Reset mid-wait
      cyc(2'b10, 1'b1, 1'b0, 4'h0, 8'h00, 8'hBB);
      chk("pre_reset_busy", {23'd0, busy}, 24'd1);
      #2 rst = 1'b1;
      #1;
      chk("reset_mid_wait", {busy, timeout_err, iss_mode, iss_cin, iss_cmd, iss_opa, iss_opb[7:2]}, 24'h0);
      chk("reset_opb", {16'd0, iss_opb}, 24'h0);
      inp_valid = 2'b00;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 20; i++) idle_cyc();
      chk("post_reset_quiet", {22'd0, busy, timeout_err}, 24'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
